// File: rtl/next_pill_monitor_pkg.sv
// Shared definitions for the next-pill countdown monitor.
//   - ch_state_e   : per-channel state (idle / counting / due)
//   - RUN_STATE    : system state value in which ticks are honoured
//   - PILLx_OFS    : bit offsets of the three intervals inside romContent
//   - DISABLED_DUR : duration shown by a channel that is not counting
//   - rom_offset() : maps channel index 0..2 to its romContent offset
package next_pill_monitor_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_COUNT = 2'd1,
        CH_DUE   = 2'd2
    } ch_state_e;

    localparam logic [3:0] RUN_STATE    = 4'd3;
    localparam int         PILL1_OFS    = 16;
    localparam int         PILL2_OFS    = 8;
    localparam int         PILL3_OFS    = 0;
    localparam logic [3:0] DISABLED_DUR = 4'd15;

    function automatic int rom_offset(input int idx);
        case (idx)
            0:       return PILL1_OFS;
            1:       return PILL2_OFS;
            default: return PILL3_OFS;
        endcase
    endfunction

endpackage

// File: rtl/next_pill_monitor_if.sv
// Bundle between the system/recorder side and the countdown monitor.
//   master : drives state, loadRom, tick, romContent, ackTaken
//            and observes durations, LEDs, alarm and missed pulses
//   slave  : the monitor itself (mirror image of master)
interface next_pill_monitor_if;
    logic [3:0]  state;
    logic        loadRom;
    logic        tick;
    logic [27:0] romContent;
    logic [2:0]  ackTaken;
    logic [11:0] pill12And3Duration;
    logic [2:0]  pillLed;
    logic        alarm;
    logic [2:0]  missedPulse;

    modport master (
        output state, loadRom, tick, romContent, ackTaken,
        input  pill12And3Duration, pillLed, alarm, missedPulse
    );

    modport slave (
        input  state, loadRom, tick, romContent, ackTaken,
        output pill12And3Duration, pillLed, alarm, missedPulse
    );
endinterface

// File: rtl/next_pill_monitor_channel.sv
// One pill channel: latches its interval on load_rom, counts down on
// qualified ticks, sits in DUE (led on) until acknowledged or until the
// grace window runs out, then reloads the interval.
//   clk, reset_n  : clock, async active-low reset
//   run           : system is in the running state
//   tick, load_rom: single-cycle pulses
//   rom_interval  : this channel's interval field
//   ack           : pill-taken acknowledge for this channel
//   duration      : remaining duration (DISABLED_DUR when idle)
//   led           : channel is due
//   missed        : one-cycle pulse on grace-expiry reload
module pill_countdown_channel
    import next_pill_monitor_pkg::*;
#(
    parameter int TICK_W      = 4,
    parameter int GRACE_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              tick,
    input  logic              load_rom,
    input  logic [TICK_W-1:0] rom_interval,
    input  logic              ack,
    output logic [TICK_W-1:0] duration,
    output logic              led,
    output logic              missed
);

    localparam logic [TICK_W-1:0] IDLE_DUR = TICK_W'(DISABLED_DUR);
    localparam logic [TICK_W-1:0] GRACE    = TICK_W'(GRACE_TICKS);

    ch_state_e         state_q,    state_d;
    logic [TICK_W-1:0] dur_q,      dur_d;
    logic [TICK_W-1:0] grace_q,    grace_d;
    logic [TICK_W-1:0] interval_q, interval_d;
    logic              missed_q,   missed_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d    = state_q;
        dur_d      = dur_q;
        grace_d    = grace_q;
        interval_d = interval_q;
        missed_d   = 1'b0;

        if (load_rom) begin
            // Reload overrides everything except reset; intervals below 2
            // leave the channel disabled.
            interval_d = rom_interval;
            grace_d    = '0;
            if (rom_interval >= TICK_W'(2)) begin
                state_d = CH_COUNT;
                dur_d   = rom_interval;
            end else begin
                state_d = CH_IDLE;
                dur_d   = IDLE_DUR;
            end
        end else begin
            case (state_q)
                CH_COUNT: begin
                    if (run && tick && dur_q != '0) begin
                        dur_d = dur_q - 1'b1;
                        if (dur_q == TICK_W'(1)) begin
                            state_d = CH_DUE;
                            grace_d = GRACE;
                        end
                    end
                end
                CH_DUE: begin
                    if (ack) begin
                        state_d = CH_COUNT;
                        dur_d   = interval_q;
                        grace_d = '0;
                    end else if (run && tick) begin
                        // The tick that takes grace to zero is the reload tick.
                        if (grace_q <= TICK_W'(1)) begin
                            state_d  = CH_COUNT;
                            dur_d    = interval_q;
                            grace_d  = '0;
                            missed_d = 1'b1;
                        end else begin
                            grace_d = grace_q - 1'b1;
                        end
                    end
                end
                CH_IDLE: ;
                default: begin
                    state_d = CH_IDLE;
                    dur_d   = IDLE_DUR;
                    grace_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q    <= CH_IDLE;
            dur_q      <= IDLE_DUR;
            grace_q    <= '0;
            interval_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            grace_q    <= grace_d;
            interval_q <= interval_d;
            missed_q   <= missed_d;
        end
    end

    assign duration = dur_q;
    assign led      = (state_q == CH_DUE);
    assign missed   = missed_q;

endmodule

// File: rtl/next_pill_monitor.sv
// Three-channel next-pill countdown feeding the pill-taken recorder.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : state/loadRom/tick/romContent/ackTaken in;
//                  pill12And3Duration/pillLed/alarm/missedPulse out
// Channel 0 is pill1: romContent[19:16], duration [11:8], bit 0 of LEDs.
module next_pill_monitor
    import next_pill_monitor_pkg::*;
#(
    parameter int TICK_W      = 4,
    parameter int GRACE_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    next_pill_monitor_if.slave   bus
);

    logic              run;
    logic [TICK_W-1:0] dur_w [3];
    logic [2:0]        led_w;
    logic [2:0]        missed_w;

    assign run = (bus.state == RUN_STATE);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        pill_countdown_channel #(
            .TICK_W      (TICK_W),
            .GRACE_TICKS (GRACE_TICKS)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .run          (run),
            .tick         (bus.tick),
            .load_rom     (bus.loadRom),
            .rom_interval (bus.romContent[rom_offset(i) +: TICK_W]),
            .ack          (bus.ackTaken[i]),
            .duration     (dur_w[i]),
            .led          (led_w[i]),
            .missed       (missed_w[i])
        );
    end

    // Pill1 occupies the most significant nibble of the duration bus.
    assign bus.pill12And3Duration = {dur_w[0], dur_w[1], dur_w[2]};
    assign bus.pillLed            = led_w;
    assign bus.alarm              = |led_w;
    assign bus.missedPulse        = missed_w;

endmodule

// File: tb/tb_next_pill_monitor.sv
module tb_next_pill_monitor;

    localparam int GRACE = 2;

    typedef struct packed {
        logic [11:0] dur;
        logic [2:0]  led;
        logic        alarm;
        logic [2:0]  missed;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n;
    next_pill_monitor_if bus ();

    next_pill_monitor #(.TICK_W(4), .GRACE_TICKS(GRACE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = counting, 2 = due.
    int   m_st  [3];
    int   m_dur [3];
    int   m_gr  [3];
    int   m_int [3];
    logic m_mis [3];
    obs_t exp_q [$];
    logic [27:0] rom;
    logic [3:0]  cur_st;

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            o.dur[11 - 4*i -: 4] = 4'(m_dur[i]);
            o.led[i]             = (m_st[i] == 2);
            o.missed[i]          = m_mis[i];
        end
        o.alarm = |o.led;
        return o;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_dur[i] = 15; m_gr[i] = 0; m_int[i] = 0; m_mis[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic ld, input logic tk,
                                       input logic [2:0] ack, input logic [3:0] st);
        int field;
        for (int i = 0; i < 3; i++) begin
            m_mis[i] = 1'b0;
            field = (i == 0) ? int'(rom[19:16]) : (i == 1) ? int'(rom[11:8]) : int'(rom[3:0]);
            if (ld) begin
                m_int[i] = field;
                m_gr[i]  = 0;
                if (field >= 2) begin m_st[i] = 1; m_dur[i] = field; end
                else            begin m_st[i] = 0; m_dur[i] = 15;    end
            end else if (m_st[i] == 1) begin
                if (st == 4'd3 && tk && m_dur[i] > 0) begin
                    m_dur[i]--;
                    if (m_dur[i] == 0) begin m_st[i] = 2; m_gr[i] = GRACE; end
                end
            end else if (m_st[i] == 2) begin
                if (ack[i]) begin
                    m_st[i] = 1; m_dur[i] = m_int[i]; m_gr[i] = 0;
                end else if (st == 4'd3 && tk) begin
                    m_gr[i]--;
                    if (m_gr[i] == 0) begin
                        m_st[i] = 1; m_dur[i] = m_int[i]; m_mis[i] = 1'b1;
                    end
                end
            end
        end
    endfunction

    obs_t last_obs;

    // One clock of stimulus: drive after the falling edge, push the expected
    // post-edge outputs, sample #1 after the rising edge and compare.
    task automatic step(input logic ld, input logic tk, input logic [2:0] ack);
        obs_t e, got;
        @(negedge clk);
        bus.loadRom    = ld;
        bus.tick       = tk;
        bus.ackTaken   = ack;
        bus.state      = cur_st;
        bus.romContent = rom;
        model_step(ld, tk, ack, cur_st);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        got = '{dur: bus.pill12And3Duration, led: bus.pillLed,
                alarm: bus.alarm, missed: bus.missedPulse};
        e = exp_q.pop_front();
        check("dur",    32'(got.dur),    32'(e.dur));
        check("led",    32'(got.led),    32'(e.led));
        check("alarm",  32'(got.alarm),  32'(e.alarm));
        check("missed", 32'(got.missed), 32'(e.missed));
        last_obs = got;
        bus.loadRom  = 1'b0;
        bus.tick     = 1'b0;
        bus.ackTaken = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'b000);
    endtask

    // Tick on the fourth cycle of each group of four.
    task automatic spaced_tick(input logic [2:0] ack);
        idle(3);
        step(1'b0, 1'b1, ack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.state = 4'd0; bus.loadRom = 1'b0; bus.tick = 1'b0;
        bus.romContent = '0; bus.ackTaken = 3'b000;
        rom = '0; cur_st = 4'd0;
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #20;
        check("rst_dur",    32'(bus.pill12And3Duration), 32'h0FFF);
        check("rst_led",    32'(bus.pillLed),            32'h0);
        check("rst_alarm",  32'(bus.alarm),              32'h0);
        check("rst_missed", 32'(bus.missedPulse),        32'h0);
        @(negedge clk) reset_n = 1'b1;

        // pill1 = 3, pill2 = 2, pill3 = 0 (disabled).
        rom = 28'h0030200;
        cur_st = 4'd3;
        step(1'b1, 1'b0, 3'b000);
        check("load_dur", 32'(last_obs.dur), 32'h032F);
        spaced_tick(3'b000);
        check("t1_dur", 32'(last_obs.dur), 32'h021F);
        spaced_tick(3'b000);
        check("t2_dur", 32'(last_obs.dur), 32'h010F);
        check("t2_led", 32'(last_obs.led), 32'b010);
        spaced_tick(3'b000);
        check("t3_dur", 32'(last_obs.dur), 32'h000F);
        check("t3_led", 32'(last_obs.led), 32'b011);

        // Ack pill1 while due.
        step(1'b0, 1'b0, 3'b001);
        check("ack_dur", 32'(last_obs.dur), 32'h030F);
        check("ack_led", 32'(last_obs.led), 32'b010);
        check("ack_mis", 32'(last_obs.missed), 32'b000);

        // Pill2's second grace tick expires it.
        spaced_tick(3'b000);
        check("miss_pulse", 32'(last_obs.missed), 32'b010);
        check("miss_dur",   32'(last_obs.dur),    32'h022F);
        step(1'b0, 1'b0, 3'b000);
        check("miss_once",  32'(last_obs.missed), 32'b000);

        // Both due, then ack arrives with the grace-expiring tick.
        spaced_tick(3'b000);
        spaced_tick(3'b000);
        check("both_due", 32'(last_obs.led), 32'b011);
        spaced_tick(3'b000);
        spaced_tick(3'b011);
        check("ack_vs_exp_mis", 32'(last_obs.missed), 32'b000);
        check("ack_vs_exp_dur", 32'(last_obs.dur),    32'h032F);

        // Pause with pill1 at 2.
        spaced_tick(3'b000);
        check("pre_pause", 32'(last_obs.dur), 32'h021F);
        cur_st = 4'd1;
        for (int k = 0; k < 10; k++) spaced_tick(3'b000);
        check("paused", 32'(last_obs.dur), 32'h021F);
        cur_st = 4'd0;
        spaced_tick(3'b000);
        check("state0_hold", 32'(last_obs.dur), 32'h021F);
        cur_st = 4'd3;
        spaced_tick(3'b000);
        check("resume", 32'(last_obs.dur), 32'h010F);

        // Ack held for several cycles: pill2 reloads once, pill1/pill3 ignore it.
        step(1'b0, 1'b0, 3'b111);
        step(1'b0, 1'b0, 3'b111);
        step(1'b0, 1'b0, 3'b111);
        check("held_ack", 32'(last_obs.dur), 32'h012F);

        // Async reset mid-count with pill1 = 1.
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_dur", 32'(bus.pill12And3Duration), 32'h0FFF);
        check("mid_rst_led", 32'(bus.pillLed),            32'h0);
        @(negedge clk) reset_n = 1'b1;
        step(1'b1, 1'b0, 3'b000);
        check("reload", 32'(last_obs.dur), 32'h032F);

        // Disabled-interval reload and a new pattern.
        rom = 28'h0010F04;
        step(1'b1, 1'b0, 3'b000);
        check("load2", 32'(last_obs.dur), 32'h0FF4);
        for (int k = 0; k < 8; k++) spaced_tick(3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/next_pill_monitor.md
Name: next_pill_monitor

Overview:
Per-pill countdown stage that sits directly upstream of the pill-taken recorder.
- Produces the packed 12-bit pill1/2/3 duration bus that the recorder watches.
- Consumes the recorder's 3-bit "taken" acknowledge and drives the pill LEDs and the alarm.
- Three identical channels count down in hour ticks from the ROM intervals, light the LED at zero, and reload when the pill is taken or when a grace window expires (missed pill).

Parameters:
- TICK_W, 4, width of the duration and grace counters.
- GRACE_TICKS, 2, ticks a channel stays due (LED on) before forced reload; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- state  in  4  system state; 0 = reset/idle, 3 = running; other values = paused.
- loadRom  in  1  single-cycle pulse: load intervals from romContent.
- tick  in  1  single-cycle time-base pulse (one duration unit).
- romContent  in  28  intervals: pill1 = [19:16], pill2 = [11:8], pill3 = [3:0].
- ackTaken  in  3  per-pill "taken" acknowledge from the recorder; bit 0 = pill1.
- pill12And3Duration  out  12  remaining duration: [11:8] pill1, [7:4] pill2, [3:0] pill3.
- pillLed  out  3  LED on while the channel is due.
- alarm  out  1  OR of pillLed.
- missedPulse  out  3  one-cycle pulse when a channel reloads due to grace expiry.

Behaviour:
- **Reset (async, reset_n = 0):**
  - every channel goes to IDLE, duration 4'd15, grace count 0;
  - pillLed = 0, alarm = 0, missedPulse = 0;
  - latched intervals = 0.
- **Interval latch:** on loadRom = 1, each channel latches its 4-bit interval from romContent.
- **Disabled channel:** a latched interval of 0 or 1 means the channel stays in IDLE and outputs duration 4'd15.
- **Channel FSM, one per pill:**
  - IDLE:
    - loadRom with a valid interval (>= 2) -> COUNT, duration <= interval.
  - COUNT:
    - state == 3 and tick: duration <= duration - 1;
    - when the decrement reaches 0 -> DUE, grace <= GRACE_TICKS.
  - DUE (duration 0, pillLed = 1):
    - ackTaken[i] -> COUNT, duration <= interval;
    - else state == 3 and tick: grace <= grace - 1;
    - grace reaching 0 -> COUNT, duration <= interval, missedPulse[i] = 1 for that cycle.
- **Latency:** all outputs are registered; duration, LED and pulse change on the clock edge after the qualifying input.
- **Priority within one cycle, highest first:** reset_n, then loadRom (all channels reload to COUNT/IDLE, grace cleared, no missedPulse), then ackTaken, then tick.
- **Simultaneous events:**
  - ackTaken and grace expiry in the same cycle: ack wins, no missedPulse;
  - ackTaken and tick in the same cycle: reload only, tick ignored;
  - ackTaken in IDLE or COUNT: ignored;
  - an ack held over several cycles reloads only once; subsequent cycles see COUNT and ignore it.
- **Pausing:** when state != 3, ticks are ignored and counters hold; the LED stays lit if DUE.
- **State 0 entered mid-operation:** counters hold; the only clear is reset_n or a reload via loadRom.
- **Arithmetic:** 4-bit unsigned, never decrements below 0, no wrap.
- **Recorder contract:** the duration sequence on every cycle is interval, ..., 1, 0, interval. A missed pill therefore reaches the recorder as a return to interval without an intervening ack.

Decomposition:
- Shared package:
  - channel state enum (IDLE, COUNT, DUE);
  - RUN_STATE = 4'd3;
  - ROM field offsets 16, 8, 0;
  - DISABLED_DUR = 4'd15.
- One sub-module, pill_countdown_channel, instantiated three times. The top level handles field slicing, output packing and the alarm OR.

Test Plan:
- Reset then loadRom with romContent[19:16] = 3, [11:8] = 2, [3:0] = 0, state = 3, ticks every 4 cycles -> pill1 reads 3, 2, 1, 0 and pillLed[0] = 1 after the third tick; pill2 is due after two ticks; pill3 holds 15 with its LED off.
- Pill1 due, ackTaken = 3'b001 for one cycle -> next cycle pill1 duration = 3, pillLed[0] = 0, missedPulse = 0.
- Pill2 due, no ack, GRACE_TICKS = 2, two ticks -> duration returns to 2, missedPulse = 3'b010 for exactly one cycle.
- Ack asserted in the same cycle as the grace-expiring tick -> reload, missedPulse stays 0.
- State = 1 (paused) for 10 ticks while pill1 = 2 -> duration stays 2; returning to state 3 resumes the countdown.
- reset_n low mid-count with pill1 = 1 -> duration immediately 15, LEDs off; loadRom after release restores the intervals.
